// File: rtl/regfile_wr_sched_if.sv
// Bundles the core writeback, NI loader and register-file write port of the
// register-file write scheduler. The slave modport is the scheduler's view.
interface regfile_wr_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wd;
    logic          core_stall;
    logic          ni_start;
    logic          ni_valid;
    logic [DW-1:0] ni_data;
    logic          ni_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wd;
    logic          pkt_done;
    logic          busy;
    logic [AW-1:0] ni_ptr;

    modport master (
        output core_we, core_addr, core_wd, ni_start, ni_valid, ni_data,
        input  core_stall, ni_ready, rf_we, rf_waddr, rf_wd, pkt_done, busy, ni_ptr
    );

    modport slave (
        input  core_we, core_addr, core_wd, ni_start, ni_valid, ni_data,
        output core_stall, ni_ready, rf_we, rf_waddr, rf_wd, pkt_done, busy, ni_ptr
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Merges core writeback and NI packet-loader writes onto one registered
// register-file write port; core has priority, bounded by a starvation counter.
module regfile_wr_sched #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int NI_FIRST   = 1,
    parameter int NI_LAST    = 7,
    parameter int PKT_LEN    = 7,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    regfile_wr_sched_if.slave bus
);
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] FIRST_A = AW'(NI_FIRST);
    localparam logic [AW-1:0] LAST_A  = AW'(NI_LAST);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ni_ptr_q, ni_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;
    logic          pkt_done_q, pkt_done_d;
    logic          busy_q, busy_d;
    logic          core_grant, ni_grant, core_stall, ni_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ni_ptr_d   = ni_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        core_grant = bus.core_we;
        ni_grant   = 1'b0;
        core_stall = 1'b0;
        ni_ready   = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wd_d    = rf_wd_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ni_start) begin
                    state_d  = ST_LOAD;
                    ni_ptr_d = FIRST_A;
                    count_d  = '0;
                    starve_d = '0;
                end
            end
            ST_LOAD: begin
                // Core wins until the NI has been denied STARVE_MAX cycles in a row.
                if (bus.core_we && (starve_q < SW'(STARVE_MAX))) begin
                    if (bus.ni_valid) starve_d = starve_q + SW'(1);
                end else if (bus.ni_valid) begin
                    core_grant = 1'b0;
                    ni_grant   = 1'b1;
                    ni_ready   = 1'b1;
                    core_stall = bus.core_we;
                    starve_d   = '0;
                end
                if (ni_grant) begin
                    ni_ptr_d = (ni_ptr_q == LAST_A) ? FIRST_A : ni_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(PKT_LEN - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Writes to the zero register are accepted but never reach the port.
        if (ni_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ni_ptr_q;
            rf_wd_d    = bus.ni_data;
        end else if (core_grant && (bus.core_addr != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.core_addr;
            rf_wd_d    = bus.core_wd;
        end

        pkt_done_d = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ni_ptr_q   <= FIRST_A;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wd_q    <= '0;
            pkt_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ni_ptr_q   <= ni_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wd_q    <= rf_wd_d;
            pkt_done_q <= pkt_done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.core_stall = core_stall;
    assign bus.ni_ready   = ni_ready;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.busy       = busy_q;
    assign bus.ni_ptr     = ni_ptr_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized scoreboard bench for regfile_wr_sched with a packet/word-count
// reference model; configured with PKT_LEN=9 so the NI window wraps.
module tb_regfile_wr_sched;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int NI_FIRST   = 1;
    localparam int NI_LAST    = 7;
    localparam int PKT_LEN    = 9;
    localparam int STARVE_MAX = 4;
    localparam int WIN        = NI_LAST - NI_FIRST + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_sched_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wr_sched #(
        .DW(DW), .AW(AW), .NI_FIRST(NI_FIRST), .NI_LAST(NI_LAST),
        .PKT_LEN(PKT_LEN), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    // Reference model: packet in progress, words accepted, consecutive NI denials.
    bit  m_in_pkt = 0;
    int  m_words  = 0;
    int  m_starve = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every registered write and pkt_done pulse must match the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
                wr_t e;
                e = exp_wr.pop_front();
                check("rf_we", bus.rf_we, 1'b1);
                if (bus.rf_we === 1'b1) begin
                    check("rf_waddr", bus.rf_waddr, e.addr);
                    check("rf_wd", bus.rf_wd, e.data);
                end
            end else begin
                check("rf_we idle", bus.rf_we, 1'b0);
            end
            if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
                void'(exp_done.pop_front());
                check("pkt_done", bus.pkt_done, 1'b1);
            end else begin
                check("pkt_done idle", bus.pkt_done, 1'b0);
            end
        end
    end

    task automatic step(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit st, input bit v, input logic [DW-1:0] nd);
        bit idle, done, load, cg, ng, exp_stall, exp_ready;
        wr_t w;
        bus.core_we   = we;
        bus.core_addr = a;
        bus.core_wd   = d;
        bus.ni_start  = st;
        bus.ni_valid  = v;
        bus.ni_data   = nd;
        #1;
        idle = !m_in_pkt;
        done = m_in_pkt && (m_words == PKT_LEN);
        load = m_in_pkt && !done;
        cg = we;
        ng = 0;
        exp_stall = 0;
        exp_ready = 0;
        if (load) begin
            if (we && m_starve < STARVE_MAX) begin
                if (v) m_starve++;
            end else if (v) begin
                cg = 0;
                ng = 1;
                exp_ready = 1;
                exp_stall = we;
                m_starve = 0;
            end
        end
        check("core_stall", bus.core_stall, exp_stall);
        check("ni_ready", bus.ni_ready, exp_ready);
        if (ng) begin
            w.addr = AW'(NI_FIRST + (m_words % WIN));
            w.data = nd;
            w.due  = cyc + 1;
            exp_wr.push_back(w);
            m_words++;
            if (m_words == PKT_LEN) exp_done.push_back(cyc + 1);
        end else if (cg && a != '0) begin
            w.addr = a;
            w.data = d;
            w.due  = cyc + 1;
            exp_wr.push_back(w);
        end
        if (idle && st) begin
            m_in_pkt = 1;
            m_words  = 0;
            m_starve = 0;
        end
        if (done) m_in_pkt = 0;
        @(posedge clk);
        #1;
        check("busy", bus.busy, m_in_pkt);
        check("ni_ptr", bus.ni_ptr, AW'(NI_FIRST + (m_words % WIN)));
    endtask

    task automatic idle_step();
        step(0, '0, '0, 0, 0, '0);
    endtask

    task automatic reset_seq(input int n);
        bus.core_we   = 1'b1;
        bus.core_addr = AW'(5);
        bus.core_wd   = 'h5A;
        bus.ni_start  = 1'b0;
        bus.ni_valid  = 1'b1;
        bus.ni_data   = 'h99;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_in_pkt = 0;
        m_words  = 0;
        m_starve = 0;
        exp_done.delete();
        check("reset rf_we", bus.rf_we, 1'b0);
        check("reset pkt_done", bus.pkt_done, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset ni_ptr", bus.ni_ptr, AW'(NI_FIRST));
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_seq(3);

        // Core write, then a zero-register write that must be silently dropped.
        step(1, AW'(5), 'hA5, 0, 0, '0);
        idle_step();
        step(1, '0, 'h77, 0, 0, '0);
        idle_step();

        // Full packet without core traffic; ni_start mid-packet and in DONE is ignored.
        step(0, '0, '0, 1, 0, '0);
        for (int i = 0; i < PKT_LEN; i++) step(0, '0, '0, (i == 3), 1, DW'(32'h10 + i));
        step(0, '0, '0, 1, 0, '0);
        idle_step();
        idle_step();

        // Starvation: core and NI both requesting every cycle.
        step(0, '0, '0, 1, 0, '0);
        for (int i = 0; i < 50; i++)
            step(1, AW'($urandom_range(1, 31)), $urandom, 0, 1, $urandom);

        // Randomized mixed traffic, zero-register writes included.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom);

        // Reset in the middle of a packet, then a fresh packet from r1.
        for (int i = 0; i < 20 && m_in_pkt; i++) idle_step();
        step(0, '0, '0, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 1, DW'(32'h40 + i));
        reset_seq(1);
        step(0, '0, '0, 1, 0, '0);
        for (int i = 0; i < 2; i++) step(0, '0, '0, 0, 1, DW'(32'h50 + i));
        repeat (3) idle_step();

        check("writes outstanding", exp_wr.size(), 0);
        check("pkt_done outstanding", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Write-port scheduler for the processor register file.
- Merges two write sources onto one registered write port:
  - the core writeback stage;
  - the network-interface (NI) packet loader, which fills a circular window of registers NI_FIRST..NI_LAST with received payload words.
- Core writes have priority; a starvation counter guarantees forward progress for the NI.
- Also sequences packet boundaries and signals packet completion.

Parameters:
- DW, 32, data width
- AW, 5, register address width
- NI_FIRST, 1, first register of NI window (must be >=1; register 0 is the zero register)
- NI_LAST, 7, last register of NI window (>= NI_FIRST)
- PKT_LEN, 7, payload words per NI packet (>=1)
- STARVE_MAX, 4, max consecutive cycles NI may be denied while valid (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- core_we  in  1  core writeback request
- core_addr  in  AW  core destination register
- core_wd  in  DW  core write data
- core_stall  out  1  combinational; core request not granted this cycle, hold inputs
- ni_start  in  1  begin new packet (accepted in IDLE only)
- ni_valid  in  1  NI payload word available
- ni_data  in  DW  NI payload word
- ni_ready  out  1  combinational; NI word consumed this cycle
- rf_we  out  1  registered write enable to register file
- rf_waddr  out  AW  registered write address
- rf_wd  out  DW  registered write data
- pkt_done  out  1  registered one-cycle pulse, packet fully written
- busy  out  1  registered, high in LOAD and DONE
- ni_ptr  out  AW  current NI window pointer (debug)

Behaviour:
- Reset (rst==0 at rising edge): state=IDLE, ni_ptr=NI_FIRST, word count=0, starve=0. rf_we, rf_waddr, rf_wd, pkt_done and busy all 0. Applies mid-packet: packet dropped, no pkt_done.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - ni_ready=0.
  - ni_start=1 -> LOAD; ni_ptr=NI_FIRST, count=0, starve=0.
- LOAD, arbitration per cycle:
  - If core_we && starve<STARVE_MAX: grant core.
    - core_stall=0, ni_ready=0.
    - If ni_valid, starve+=1.
  - Else if ni_valid: grant NI.
    - ni_ready=1, starve=0.
    - core_stall=core_we.
  - Else: grant core if core_we; starve unchanged.
- NI grant:
  - Write ni_data to ni_ptr.
  - ni_ptr = (ni_ptr==NI_LAST) ? NI_FIRST : ni_ptr+1.
  - count+=1.
  - If this is word PKT_LEN (count==PKT_LEN-1 before increment) -> DONE.
- DONE: one cycle.
  - pkt_done=1, ni_ready=0 -> IDLE.
  - ni_start is ignored here; the source must re-present it in IDLE.
- Outside LOAD: core always granted, core_stall=0.
- ni_start in LOAD/DONE: ignored.
- Latency: a grant in cycle t appears on rf_we/rf_waddr/rf_wd at t+1. Exactly one write per cycle max, so no same-address collision is possible.
- core_addr==0: request accepted (no stall) but rf_we stays 0. NI never targets register 0 (window excludes it).
- No grant in cycle t: rf_we=0 at t+1. rf_waddr/rf_wd hold their previous values.
- PKT_LEN > window size: the pointer wraps and overwrites earlier words; this is legal.
- Arithmetic: ni_ptr compare/increment in AW bits; count and starve counters are sized to hold PKT_LEN and STARVE_MAX.

Test Plan:
- Reset/idle: hold rst=0 3 cycles with core_we=1 -> rf_we=0, pkt_done=0, busy=0, ni_ptr=1. Release; core_we=1, addr=5, wd=0xA5 -> next cycle rf_we=1, rf_waddr=5, rf_wd=0xA5.
- Packet without core traffic: ni_start then 7 valid words 0x10..0x16 -> writes to r1..r7 on consecutive cycles. pkt_done pulses one cycle after the 7th write is granted; busy falls the cycle after that.
- Starvation: LOAD, core_we and ni_valid held continuously -> core granted 4 cycles, NI granted on the 5th (core_stall=1 that cycle only), then the pattern repeats.
- Wrap: PKT_LEN=9, NI_FIRST=1, NI_LAST=7 -> addresses 1,2,...,7,1,2. pkt_done after the 9th word.
- Zero register / boundaries:
  - core_addr=0 -> no stall, rf_we=0.
  - ni_start during LOAD -> no pointer reset.
  - ni_start during DONE -> ignored; packet starts only when re-asserted in IDLE.
- Reset mid-packet: assert rst after 3 NI words -> next cycle IDLE, ni_ptr=1, no pkt_done. A new packet restarts at r1.
